// File: rtl/intra16_mode_decider_if.sv
// ============================================================================
// intra16_mode_decider_if : request/result bundle for the intra 16x16 mode decider
// Rev 1.0
// ============================================================================
`default_nettype none

interface intra16_mode_decider_if #(
   parameter int MB_SIZE = 16
);
   logic       start;
   logic       top_avail;
   logic       left_avail;
   logic [7:0] mb         [MB_SIZE*MB_SIZE];
   logic [7:0] toppixels  [MB_SIZE];
   logic [7:0] leftpixels [MB_SIZE];
   logic       busy;
   logic       done;
   logic [1:0] best_mode;
   logic [15:0] best_sad;
   logic [7:0] dc_value;
   logic [7:0] pred_mb    [MB_SIZE*MB_SIZE];

   modport master (
      output start, top_avail, left_avail, mb, toppixels, leftpixels,
      input  busy, done, best_mode, best_sad, dc_value, pred_mb
   );

   modport slave (
      input  start, top_avail, left_avail, mb, toppixels, leftpixels,
      output busy, done, best_mode, best_sad, dc_value, pred_mb
   );
endinterface

`default_nettype wire

// File: rtl/intra16_mode_decider.sv
// ============================================================================
// intra16_mode_decider : Vertical/Horizontal/DC SAD mode decision for 16x16 luma
// Rev 1.0
// ============================================================================
`default_nettype none

module intra16_mode_decider #(
   parameter int MB_SIZE = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   intra16_mode_decider_if.slave bus
);
   localparam int         NPIX     = MB_SIZE * MB_SIZE;
   localparam logic [3:0] ROW_LAST = 4'(MB_SIZE - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DCSUM = 2'd1,
      SAD   = 2'd2,
      FINAL = 2'd3
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [7:0]  mb_q   [NPIX];
   logic [7:0]  top_q  [MB_SIZE];
   logic [7:0]  left_q [MB_SIZE];
   logic        top_av;
   logic        left_av;

   logic [7:0]  dc_q;
   logic [1:0]  mode_cnt;
   logic [3:0]  row_cnt;
   logic [15:0] acc;
   logic [15:0] cand_sad;
   logic [1:0]  cand_mode;

   logic [12:0] sum_top;
   logic [12:0] sum_left;
   logic [7:0]  dc_calc;
   logic [11:0] row_sad;
   logic [15:0] mode_sad;
   logic        mode_valid;

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = DCSUM;
         DCSUM:   state_nxt = SAD;
         SAD:     if (mode_cnt == 2'd2 && row_cnt == ROW_LAST) state_nxt = FINAL;
         FINAL:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Working copy of the request; the source may move on right after capture.
   always_ff @(posedge clk) begin
      if (state == IDLE && bus.start) begin
         mb_q    <= bus.mb;
         top_q   <= bus.toppixels;
         left_q  <= bus.leftpixels;
         top_av  <= bus.top_avail;
         left_av <= bus.left_avail;
      end
   end

   always_comb begin
      sum_top  = '0;
      sum_left = '0;
      for (int i = 0; i < MB_SIZE; i++) begin
         sum_top  = sum_top  + 13'(top_q[i]);
         sum_left = sum_left + 13'(left_q[i]);
      end
      case ({top_av, left_av})
         2'b11:   dc_calc = 8'((14'(sum_top) + 14'(sum_left) + 14'd16) >> 5);
         2'b10:   dc_calc = 8'((sum_top + 13'd8) >> 4);
         2'b01:   dc_calc = 8'((sum_left + 13'd8) >> 4);
         default: dc_calc = 8'd128;
      endcase
   end

   // One row of absolute differences for the mode under evaluation.
   always_comb begin
      logic [7:0] pv;
      logic [7:0] sv;
      row_sad = '0;
      for (int c = 0; c < MB_SIZE; c++) begin
         case (mode_cnt)
            2'd0:    pv = top_q[c];
            2'd1:    pv = left_q[row_cnt];
            default: pv = dc_q;
         endcase
         sv      = mb_q[{row_cnt, 4'(c)}];
         row_sad = row_sad + 12'((sv > pv) ? (sv - pv) : (pv - sv));
      end
      mode_sad   = ((row_cnt == 4'd0) ? 16'd0 : acc) + 16'(row_sad);
      mode_valid = (mode_cnt == 2'd2) ||
                   (mode_cnt == 2'd0 && top_av) ||
                   (mode_cnt == 2'd1 && left_av);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.best_mode <= 2'd0;
         bus.best_sad  <= 16'd0;
         bus.dc_value  <= 8'd0;
         for (int i = 0; i < NPIX; i++) bus.pred_mb[i] <= 8'd0;
         dc_q      <= 8'd0;
         mode_cnt  <= 2'd0;
         row_cnt   <= 4'd0;
         acc       <= 16'd0;
         cand_sad  <= 16'hFFFF;
         cand_mode <= 2'd2;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) bus.busy <= 1'b1;
            end
            DCSUM: begin
               dc_q      <= dc_calc;
               cand_sad  <= 16'hFFFF;
               cand_mode <= 2'd2;
               mode_cnt  <= 2'd0;
               row_cnt   <= 4'd0;
            end
            SAD: begin
               acc     <= mode_sad;
               row_cnt <= row_cnt + 4'd1;
               if (row_cnt == ROW_LAST) begin
                  mode_cnt <= mode_cnt + 2'd1;
                  // Strict compare: a tie keeps the earlier (lower) mode.
                  if (mode_valid && mode_sad < cand_sad) begin
                     cand_sad  <= mode_sad;
                     cand_mode <= mode_cnt;
                  end
               end
            end
            FINAL: begin
               bus.busy      <= 1'b0;
               bus.done      <= 1'b1;
               bus.best_mode <= cand_mode;
               bus.best_sad  <= cand_sad;
               bus.dc_value  <= dc_q;
               for (int i = 0; i < NPIX; i++) begin
                  case (cand_mode)
                     2'd0:    bus.pred_mb[i] <= top_q[i % MB_SIZE];
                     2'd1:    bus.pred_mb[i] <= left_q[i / MB_SIZE];
                     default: bus.pred_mb[i] <= dc_q;
                  endcase
               end
            end
            default: ;
         endcase
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_intra16_mode_decider.sv
// ============================================================================
// tb_intra16_mode_decider : scoreboard bench for the intra 16x16 mode decider
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_intra16_mode_decider;
   logic clk;
   logic reset;

   intra16_mode_decider_if #(.MB_SIZE(16)) bus ();

   intra16_mode_decider #(.MB_SIZE(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  mode;
      logic [15:0] sad;
      logic [7:0]  dc;
      logic [7:0]  pred [256];
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   logic [7:0] s_mb   [256];
   logic [7:0] s_top  [16];
   logic [7:0] s_left [16];
   logic       s_ta;
   logic       s_la;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic exp_t model_mb();
      exp_t e;
      int   st, sl, dc, p, d, best_m, best_s;
      int   sad [3];
      bit   valid [3];
      st = 0; sl = 0;
      for (int i = 0; i < 16; i++) begin
         st += int'(s_top[i]);
         sl += int'(s_left[i]);
      end
      if (s_ta && s_la) dc = (st + sl + 16) / 32;
      else if (s_ta)    dc = (st + 8) / 16;
      else if (s_la)    dc = (sl + 8) / 16;
      else              dc = 128;
      for (int m = 0; m < 3; m++) begin
         sad[m] = 0;
         for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
               p = (m == 0) ? int'(s_top[c]) : (m == 1) ? int'(s_left[r]) : dc;
               d = int'(s_mb[r*16+c]) - p;
               sad[m] += (d < 0) ? -d : d;
            end
      end
      valid[0] = s_ta; valid[1] = s_la; valid[2] = 1'b1;
      best_m = -1; best_s = 0;
      for (int m = 0; m < 3; m++)
         if (valid[m] && (best_m < 0 || sad[m] < best_s)) begin
            best_m = m; best_s = sad[m];
         end
      e.mode = 2'(best_m);
      e.sad  = 16'(best_s);
      e.dc   = 8'(dc);
      for (int i = 0; i < 256; i++)
         e.pred[i] = (best_m == 0) ? s_top[i%16] : (best_m == 1) ? s_left[i/16] : 8'(dc);
      return e;
   endfunction

   function automatic int pred_nonzero();
      int n = 0;
      for (int i = 0; i < 256; i++) if (bus.pred_mb[i] != 8'd0) n++;
      return n;
   endfunction

   // Scoreboard side: compare every completed macroblock against the oldest expectation.
   always @(posedge clk) begin
      #1;
      if (bus.done === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            int   bad;
            e = sb_q.pop_front();
            check("best_mode", bus.best_mode, e.mode);
            check("best_sad", bus.best_sad, e.sad);
            check("dc_value", bus.dc_value, e.dc);
            bad = 0;
            for (int i = 0; i < 256; i++) if (bus.pred_mb[i] !== e.pred[i]) bad++;
            check("pred_mb_mismatches", bad, 0);
         end
      end
   end

   task automatic run_mb(input int restart_at, input int reset_at);
      int lat;
      int extra;
      bit seen;
      @(posedge clk); #1;
      bus.mb = s_mb; bus.toppixels = s_top; bus.leftpixels = s_left;
      bus.top_avail = s_ta; bus.left_avail = s_la;
      bus.start = 1'b1;
      if (reset_at == 0) sb_q.push_back(model_mb());
      lat = 0; seen = 0;
      while (!seen && lat < 70) begin
         @(posedge clk); #1;
         lat++;
         bus.start = (restart_at != 0 && lat == restart_at - 1);
         if (lat == 1) begin
            for (int i = 0; i < 256; i++) bus.mb[i] = 8'($urandom);
            for (int i = 0; i < 16; i++) begin
               bus.toppixels[i]  = 8'($urandom);
               bus.leftpixels[i] = 8'($urandom);
            end
            bus.top_avail = ~s_ta; bus.left_avail = ~s_la;
            check("busy_after_start", bus.busy, 1);
         end
         if (reset_at != 0 && lat == reset_at - 1) reset = 1'b0;
         if (reset_at != 0 && lat == reset_at) begin
            check("rst_busy", bus.busy, 0);
            check("rst_done", bus.done, 0);
            check("rst_best_mode", bus.best_mode, 0);
            check("rst_best_sad", bus.best_sad, 0);
            check("rst_dc_value", bus.dc_value, 0);
            check("rst_pred_nonzero", pred_nonzero(), 0);
            reset = 1'b1;
            seen = 1;
         end
         if (bus.done === 1'b1) seen = 1;
      end
      if (reset_at == 0) begin
         check("latency", lat, 51);
         check("busy_at_done", bus.busy, 0);
         @(posedge clk); #1;
         check("done_fall", bus.done, 0);
         if (restart_at != 0) begin
            extra = 0;
            repeat (55) begin
               @(posedge clk); #1;
               if (bus.done === 1'b1) extra++;
            end
            check("no_extra_done", extra, 0);
         end
      end else begin
         extra = 0;
         repeat (60) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) extra++;
         end
         check("no_done_after_reset", extra, 0);
      end
   endtask

   task automatic fill_const(input logic [7:0] mv, input logic [7:0] tv, input logic [7:0] lv,
                             input logic ta, input logic la);
      for (int i = 0; i < 256; i++) s_mb[i] = mv;
      for (int i = 0; i < 16; i++) begin
         s_top[i] = tv; s_left[i] = lv;
      end
      s_ta = ta; s_la = la;
   endtask

   function automatic logic [7:0] clamp8(input int v);
      if (v < 0)   return 8'd0;
      if (v > 255) return 8'd255;
      return 8'(v);
   endfunction

   initial begin
      int kind;
      reset = 1'b0;
      bus.start = 1'b0; bus.top_avail = 1'b0; bus.left_avail = 1'b0;
      for (int i = 0; i < 256; i++) bus.mb[i] = 8'd0;
      for (int i = 0; i < 16; i++) begin
         bus.toppixels[i] = 8'd0; bus.leftpixels[i] = 8'd0;
      end
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", bus.busy, 0);
      check("reset_done", bus.done, 0);
      check("reset_best_sad", bus.best_sad, 0);
      check("reset_dc_value", bus.dc_value, 0);
      check("reset_pred_nonzero", pred_nonzero(), 0);
      reset = 1'b1;

      fill_const(8'd100, 8'd100, 8'd100, 1'b1, 1'b1);
      run_mb(0, 0);

      fill_const(8'd0, 8'd0, 8'd0, 1'b0, 1'b1);
      for (int r = 0; r < 16; r++) begin
         s_left[r] = 8'(10 * r);
         for (int c = 0; c < 16; c++) s_mb[r*16+c] = 8'(10 * r);
      end
      run_mb(0, 0);

      fill_const(8'd128, 8'd37, 8'd201, 1'b0, 1'b0);
      run_mb(0, 0);

      fill_const(8'd255, 8'd0, 8'd0, 1'b1, 1'b1);
      run_mb(0, 0);

      fill_const(8'd77, 8'd70, 8'd80, 1'b1, 1'b1);
      run_mb(10, 0);

      fill_const(8'd100, 8'd100, 8'd100, 1'b1, 1'b1);
      run_mb(0, 0);
      fill_const(8'd50, 8'd10, 8'd20, 1'b1, 1'b1);
      run_mb(0, 20);
      fill_const(8'd50, 8'd10, 8'd20, 1'b1, 1'b1);
      run_mb(0, 0);

      for (int n = 0; n < 500; n++) begin
         kind = $urandom_range(0, 3);
         s_ta = 1'($urandom); s_la = 1'($urandom);
         for (int i = 0; i < 16; i++) begin
            s_top[i] = 8'($urandom); s_left[i] = 8'($urandom);
         end
         for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
               case (kind)
                  0: s_mb[r*16+c] = 8'($urandom);
                  1: s_mb[r*16+c] = clamp8(int'(s_top[c]) + $urandom_range(0, 6) - 3);
                  2: s_mb[r*16+c] = clamp8(int'(s_left[r]) + $urandom_range(0, 6) - 3);
                  default: s_mb[r*16+c] = clamp8(int'(s_top[0]) + $urandom_range(0, 6) - 3);
               endcase
            end
         run_mb(0, 0);
      end

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_empty", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
